// File: rtl/rob_drain_scheduler_if.sv
// Enqueue, open-row, drain-control and ROB read-port signals of the ROB drain scheduler.
// The scheduler connects through the slave modport; the driving side uses master.
interface rob_drain_scheduler_if #(
  parameter int unsigned ROW_W = 11
);
  logic             iEnqValid;
  logic [ROW_W-1:0] iEnqRow;
  logic             oEnqReady;
  logic             iOpenRowValid;
  logic [ROW_W-1:0] iOpenRow;
  logic             iDrainEn;
  logic             oROB_Rd;
  logic [ROW_W-1:0] oROB_Row;
  logic             iROB_ItemValid;
  logic             iROB_ItemEnd;
  logic             oBusy;
  logic [2:0]       oPending;
  logic             oCntErr;

  modport slave (
    input  iEnqValid, iEnqRow, iOpenRowValid, iOpenRow, iDrainEn,
           iROB_ItemValid, iROB_ItemEnd,
    output oEnqReady, oROB_Rd, oROB_Row, oBusy, oPending, oCntErr
  );

  modport master (
    output iEnqValid, iEnqRow, iOpenRowValid, iOpenRow, iDrainEn,
           iROB_ItemValid, iROB_ItemEnd,
    input  oEnqReady, oROB_Rd, oROB_Row, oBusy, oPending, oCntErr
  );
endinterface

// File: rtl/rob_drain_scheduler.sv
// Picks the next DRAM row to drain from the ROB using a small pending-row table
// (count + age per row), issues a one-cycle read and waits for the item-end indication.
module rob_drain_scheduler #(
  parameter int unsigned ROW_W   = 11,
  parameter int unsigned NENT    = 4,
  parameter int unsigned WAYS    = 8,
  parameter int unsigned AGE_MAX = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  rob_drain_scheduler_if.slave  bus
);

  localparam int unsigned IDX_W = (NENT > 1) ? $clog2(NENT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_END
  } state_t;

  state_t state, stateNext;

  logic             entValid [NENT];
  logic [ROW_W-1:0] entRow   [NENT];
  logic [3:0]       entCnt   [NENT];
  logic [5:0]       entAge   [NENT];

  logic [IDX_W-1:0] selIdx;
  logic [ROW_W-1:0] robRow;
  logic [3:0]       beats;
  logic             cntErr;
  logic [2:0]       pending;

  // Enqueue lookup
  logic             hitAny, freeAny;
  logic [IDX_W-1:0] hitIdx, freeIdx;
  logic             enqReady, enqHit, enqAlloc;

  // Drain selection
  logic             fullAny, agedAny, openAny, bigAny, pickAny;
  logic [IDX_W-1:0] fullIdx, agedIdx, openIdx, bigIdx, pickIdx;
  logic [3:0]       bigCnt;

  // FSM strobes and beat bookkeeping
  logic             startDrain, endDrain, draining;
  logic [IDX_W-1:0] drainIdx;
  logic [3:0]       beatsTot;

  always_comb begin
    hitAny  = 1'b0;
    hitIdx  = '0;
    freeAny = 1'b0;
    freeIdx = '0;
    for (int unsigned i = 0; i < NENT; i++) begin
      if (!hitAny && entValid[i] && (entRow[i] == bus.iEnqRow)) begin
        hitAny = 1'b1;
        hitIdx = IDX_W'(i);
      end
      if (!freeAny && !entValid[i]) begin
        freeAny = 1'b1;
        freeIdx = IDX_W'(i);
      end
    end
  end

  // A hit on the row under drain is refused so its count stays consistent with the read-out.
  always_comb begin
    enqReady = freeAny;
    if (hitAny) begin
      enqReady = (entCnt[hitIdx] != 4'(WAYS)) &&
                 !((state != IDLE) && (hitIdx == selIdx));
    end
  end

  assign enqHit   = bus.iEnqValid && enqReady && hitAny;
  assign enqAlloc = bus.iEnqValid && enqReady && !hitAny;

  // Each tier takes the lowest matching index; largest count keeps the first maximum.
  always_comb begin
    fullAny = 1'b0;
    fullIdx = '0;
    agedAny = 1'b0;
    agedIdx = '0;
    openAny = 1'b0;
    openIdx = '0;
    bigAny  = 1'b0;
    bigIdx  = '0;
    bigCnt  = '0;
    for (int unsigned i = 0; i < NENT; i++) begin
      if (entValid[i]) begin
        if (!fullAny && (entCnt[i] == 4'(WAYS))) begin
          fullAny = 1'b1;
          fullIdx = IDX_W'(i);
        end
        if (!agedAny && (entAge[i] == 6'(AGE_MAX))) begin
          agedAny = 1'b1;
          agedIdx = IDX_W'(i);
        end
        if (!openAny && bus.iOpenRowValid && (entRow[i] == bus.iOpenRow)) begin
          openAny = 1'b1;
          openIdx = IDX_W'(i);
        end
        if (entCnt[i] > bigCnt) begin
          bigAny = 1'b1;
          bigIdx = IDX_W'(i);
          bigCnt = entCnt[i];
        end
      end
    end
  end

  always_comb begin
    pickAny = fullAny || agedAny || openAny || bigAny;
    if (fullAny)      pickIdx = fullIdx;
    else if (agedAny) pickIdx = agedIdx;
    else if (openAny) pickIdx = openIdx;
    else              pickIdx = bigIdx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    startDrain = 1'b0;
    endDrain   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.iDrainEn && (pending != '0) && pickAny) begin
          startDrain = 1'b1;
          stateNext  = ISSUE;
        end
      end
      ISSUE: stateNext = WAIT_END;
      WAIT_END: begin
        if (bus.iROB_ItemEnd) begin
          endDrain  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // The entry being picked this cycle is already exempt from ageing.
  assign draining = startDrain || (state != IDLE);
  assign drainIdx = startDrain ? pickIdx : selIdx;
  assign beatsTot = (bus.iROB_ItemValid && (beats != 4'hF)) ? beats + 4'd1 : beats;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entValid <= '{default: '0};
      entRow   <= '{default: '0};
      entCnt   <= '{default: '0};
      entAge   <= '{default: '0};
    end else begin
      for (int unsigned i = 0; i < NENT; i++) begin
        if (entValid[i] && !(draining && (drainIdx == IDX_W'(i))) &&
            (entAge[i] != 6'(AGE_MAX))) begin
          entAge[i] <= entAge[i] + 6'd1;
        end
        if (enqHit && (hitIdx == IDX_W'(i))) begin
          entCnt[i] <= entCnt[i] + 4'd1;
        end
        if (endDrain && (selIdx == IDX_W'(i))) begin
          entValid[i] <= 1'b0;
        end
        if (enqAlloc && (freeIdx == IDX_W'(i))) begin
          entValid[i] <= 1'b1;
          entRow[i]   <= bus.iEnqRow;
          entCnt[i]   <= 4'd1;
          entAge[i]   <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      selIdx  <= '0;
      robRow  <= '0;
      beats   <= '0;
      cntErr  <= 1'b0;
      pending <= '0;
    end else begin
      if (startDrain) begin
        selIdx <= pickIdx;
        robRow <= entRow[pickIdx];
      end
      if (state == ISSUE)         beats <= '0;
      else if (state == WAIT_END) beats <= beatsTot;
      cntErr  <= endDrain && (beatsTot != entCnt[selIdx]);
      pending <= pending + 3'(enqAlloc) - 3'(endDrain);
    end
  end

  assign bus.oEnqReady = enqReady;
  assign bus.oROB_Rd   = (state == ISSUE);
  assign bus.oROB_Row  = robRow;
  assign bus.oBusy     = (state != IDLE);
  assign bus.oPending  = pending;
  assign bus.oCntErr   = cntErr;

endmodule

// File: tb/tb_rob_drain_scheduler.sv
// Directed per-cycle vectors for rob_drain_scheduler: inputs are applied after the falling
// edge, outputs checked 1 ns later (registered state from the last rising edge).
module tb_rob_drain_scheduler;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  rob_drain_scheduler_if #(.ROW_W(11)) bus ();

  rob_drain_scheduler #(
    .ROW_W  (11),
    .NENT   (4),
    .WAYS   (8),
    .AGE_MAX(63)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic [10:0] er;
    logic        ov;
    logic [10:0] orow;
    logic        de;
    logic        iv;
    logic        ie;
    logic        rdy;
    logic        rd;
    logic [10:0] row;
    logic        busy;
    logic [2:0]  pend;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic ev, input logic [10:0] er, input logic ov, input logic [10:0] orow,
    input logic de, input logic iv, input logic ie,
    input logic rdy, input logic rd, input logic [10:0] row, input logic busy,
    input logic [2:0] pend, input logic err);
    vec_t v;
    v.ev = ev;   v.er = er;   v.ov = ov;     v.orow = orow;
    v.de = de;   v.iv = iv;   v.ie = ie;
    v.rdy = rdy; v.rd = rd;   v.row = row;   v.busy = busy;
    v.pend = pend; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.iEnqValid      = v.ev;
    bus.iEnqRow        = v.er;
    bus.iOpenRowValid  = v.ov;
    bus.iOpenRow       = v.orow;
    bus.iDrainEn       = v.de;
    bus.iROB_ItemValid = v.iv;
    bus.iROB_ItemEnd   = v.ie;
  endtask

  task automatic runVec(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #1;
    check({tag, ".rdy"},  32'(bus.oEnqReady), 32'(v.rdy));
    check({tag, ".rd"},   32'(bus.oROB_Rd),   32'(v.rd));
    check({tag, ".busy"}, 32'(bus.oBusy),     32'(v.busy));
    check({tag, ".pend"}, 32'(bus.oPending),  32'(v.pend));
    check({tag, ".err"},  32'(bus.oCntErr),   32'(v.err));
    if (v.busy) check({tag, ".row"}, 32'(bus.oROB_Row), 32'(v.row));
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, ".rd"},   32'(bus.oROB_Rd),  32'd0);
    check({tag, ".row"},  32'(bus.oROB_Row), 32'd0);
    check({tag, ".busy"}, 32'(bus.oBusy),    32'd0);
    check({tag, ".pend"}, 32'(bus.oPending), 32'd0);
    check({tag, ".err"},  32'(bus.oCntErr),  32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    checkResetOutputs("por");
    @(negedge clk);
    reset = 1'b0;

    //          ev er     ov orow   de iv ie | rdy rd row    busy pend err
    // largest-count pick, matched beat count
    tbl.push_back(mk(0, 0,      0, 0,      0, 0, 0,  1, 0, 0,      0, 0, 0));
    tbl.push_back(mk(1, 11'h10, 0, 0,      0, 0, 0,  1, 0, 0,      0, 0, 0));
    tbl.push_back(mk(1, 11'h20, 0, 0,      0, 0, 0,  1, 0, 0,      0, 1, 0));
    tbl.push_back(mk(1, 11'h10, 0, 0,      0, 0, 0,  1, 0, 0,      0, 2, 0));
    tbl.push_back(mk(0, 0,      0, 0,      0, 0, 0,  1, 0, 0,      0, 2, 0));
    tbl.push_back(mk(0, 0,      0, 0,      1, 0, 0,  1, 0, 0,      0, 2, 0));
    tbl.push_back(mk(0, 0,      0, 0,      0, 0, 0,  1, 1, 11'h10, 1, 2, 0));
    tbl.push_back(mk(0, 0,      0, 0,      0, 1, 0,  1, 0, 11'h10, 1, 2, 0));
    tbl.push_back(mk(0, 0,      0, 0,      0, 1, 1,  1, 0, 11'h10, 1, 2, 0));
    // open-row hit beats larger count; end coincident with last beat
    tbl.push_back(mk(1, 11'h10, 0, 0,      0, 0, 0,  1, 0, 0,      0, 1, 0));
    tbl.push_back(mk(1, 11'h10, 0, 0,      0, 0, 0,  1, 0, 0,      0, 2, 0));
    tbl.push_back(mk(1, 11'h10, 0, 0,      0, 0, 0,  1, 0, 0,      0, 2, 0));
    tbl.push_back(mk(0, 0,      1, 11'h20, 1, 0, 0,  1, 0, 0,      0, 2, 0));
    tbl.push_back(mk(0, 0,      0, 0,      0, 0, 0,  1, 1, 11'h20, 1, 2, 0));
    tbl.push_back(mk(0, 0,      0, 0,      0, 1, 1,  1, 0, 11'h20, 1, 2, 0));
    // enqueue to the row under drain refused; 2 beats vs count 3
    tbl.push_back(mk(0, 0,      0, 0,      1, 0, 0,  1, 0, 0,      0, 1, 0));
    tbl.push_back(mk(1, 11'h10, 0, 0,      0, 0, 0,  0, 1, 11'h10, 1, 1, 0));
    tbl.push_back(mk(1, 11'h10, 0, 0,      0, 1, 0,  0, 0, 11'h10, 1, 1, 0));
    tbl.push_back(mk(0, 0,      0, 0,      0, 1, 0,  1, 0, 11'h10, 1, 1, 0));
    tbl.push_back(mk(0, 0,      0, 0,      0, 0, 1,  1, 0, 11'h10, 1, 1, 0));
    tbl.push_back(mk(0, 0,      0, 0,      0, 0, 0,  1, 0, 0,      0, 0, 1));
    tbl.push_back(mk(0, 0,      0, 0,      0, 0, 0,  1, 0, 0,      0, 0, 0));

    foreach (tbl[i]) runVec(tbl[i], $sformatf("tbl%0d", i));

    // Saturated age wins over the open-row hit
    resetDut();
    runVec(mk(1, 11'h30, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "age.enq30");
    for (int i = 0; i < 70; i++) runVec(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0), "age.hold");
    runVec(mk(1, 11'h40, 0, 0,      0, 0, 0, 1, 0, 0,      0, 1, 0), "age.enq40");
    runVec(mk(0, 0,      1, 11'h40, 1, 0, 0, 1, 0, 0,      0, 2, 0), "age.sel");
    runVec(mk(0, 0,      0, 0,      0, 0, 0, 1, 1, 11'h30, 1, 2, 0), "age.rd");
    runVec(mk(0, 0,      0, 0,      0, 1, 1, 1, 0, 11'h30, 1, 2, 0), "age.end");
    runVec(mk(0, 0,      0, 0,      0, 0, 0, 1, 0, 0,      0, 1, 0), "age.after");

    // Full table, full row, free and miss-allocate in the same cycle
    resetDut();
    runVec(mk(1, 11'h50, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "full.e0");
    runVec(mk(1, 11'h51, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0), "full.e1");
    runVec(mk(1, 11'h52, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0), "full.e2");
    runVec(mk(1, 11'h53, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0), "full.e3");
    runVec(mk(1, 11'h54, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0), "full.fifth");
    for (int i = 0; i < 7; i++) runVec(mk(1, 11'h52, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4, 0), "full.ways");
    runVec(mk(1, 11'h52, 0, 0,      0, 0, 0, 0, 0, 0,      0, 4, 0), "full.ninth");
    runVec(mk(0, 0,      1, 11'h50, 1, 0, 0, 0, 0, 0,      0, 4, 0), "full.sel");
    runVec(mk(0, 0,      0, 0,      0, 0, 0, 0, 1, 11'h52, 1, 4, 0), "full.rd");
    for (int i = 0; i < 7; i++) runVec(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 11'h52, 1, 4, 0), "full.beat");
    runVec(mk(1, 11'h54, 0, 0, 0, 1, 1, 0, 0, 11'h52, 1, 4, 0), "full.endmiss");
    runVec(mk(1, 11'h54, 0, 0, 0, 0, 0, 1, 0, 0,      0, 3, 0), "full.realloc");

    // Reset while waiting for item end, then restart from an empty table
    runVec(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0,      0, 4, 0), "rst.sel");
    runVec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 11'h50, 1, 4, 0), "rst.rd");
    runVec(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 11'h50, 1, 4, 0), "rst.wait");
    @(negedge clk);
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkResetOutputs("rst.async");
    @(negedge clk);
    reset = 1'b0;
    runVec(mk(1, 11'h60, 0, 0, 0, 0, 0, 1, 0, 0,      0, 0, 0), "rst.enq");
    runVec(mk(0, 0,      0, 0, 1, 0, 0, 1, 0, 0,      0, 1, 0), "rst.sel2");
    runVec(mk(0, 0,      0, 0, 0, 0, 0, 1, 1, 11'h60, 1, 1, 0), "rst.rd2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rob_drain_scheduler.md
Name: rob_drain_scheduler

Overview:
- Sequences draining of the reorder buffer (ROB) by deciding which DRAM row to read out next.
- Tracks a small table of rows that currently hold pending ROB items, with an item count and an age per row.
- Issues one-cycle ROB read commands (row address) and waits for the ROB's item-end indication before the next issue.
- Sits between the request front-end (which writes items into the ROB) and the ROB's read port; chooses rows to favour open-row hits while bounding starvation.

Parameters:
- ROW_W, 11, width of DRAM row address (matches ROB row index)
- NENT, 4, number of pending-row table entries
- WAYS, 8, maximum items per row held in the ROB
- AGE_MAX, 63, saturating age threshold that forces a drain

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- iEnqValid  in  1  front-end is writing one item for row iEnqRow into the ROB
- iEnqRow  in  ROW_W  row of the enqueued item
- oEnqReady  out  1  enqueue accepted this cycle (combinational from table state and iEnqRow)
- iOpenRowValid  in  1  a DRAM row is currently open
- iOpenRow  in  ROW_W  currently open row
- iDrainEn  in  1  downstream permits starting a new drain
- oROB_Rd  out  1  one-cycle ROB read command
- oROB_Row  out  ROW_W  row for oROB_Rd, held stable until drain completes
- iROB_ItemValid  in  1  ROB is delivering one item
- iROB_ItemEnd  in  1  ROB drain of the current row finished
- oBusy  out  1  drain in progress (ISSUE or WAIT_END)
- oPending  out  3  number of valid table entries, 0..NENT
- oCntErr  out  1  one-cycle pulse: items delivered does not equal the entry's count

Behaviour:
- Reset (asynchronous, active-high): all entries invalid, counts and ages 0, state IDLE. Outputs during reset: oROB_Rd=0, oROB_Row=0, oBusy=0, oPending=0, oCntErr=0. Reset mid-drain abandons the drain with no end handshake.
- Table entry fields: valid, row[ROW_W], cnt[4] (1..WAYS), age[6].
- Enqueue (accepted when iEnqValid & oEnqReady):
  - Hit (valid entry with row == iEnqRow): cnt += 1.
  - Miss: allocate the lowest-index free entry with cnt=1, age=0.
  - oEnqReady=0 when any of the following holds:
    - hit entry has cnt==WAYS;
    - miss and table full;
    - hit entry is the one being drained (state ISSUE or WAIT_END).
- Age: each cycle every valid entry not selected for draining gets age+1, saturating at AGE_MAX.
- FSM IDLE -> ISSUE -> WAIT_END -> IDLE.
  - IDLE: if iDrainEn and oPending != 0, select an entry and go to ISSUE. Selection priority uses state before this cycle's enqueue:
    1. cnt==WAYS
    2. age==AGE_MAX
    3. iOpenRowValid & row==iOpenRow
    4. largest cnt
    - Ties at any level go to the lowest index.
    - An enqueue hitting the selected entry in the same IDLE cycle is accepted and counted.
  - ISSUE: oROB_Rd=1 for exactly one cycle; oROB_Row=selected row (registered, valid from ISSUE until return to IDLE). Clear the beat counter. Go to WAIT_END.
  - WAIT_END:
    - Count iROB_ItemValid beats (4-bit, saturating at 15).
    - On iROB_ItemEnd: free the entry (valid=0) and go to IDLE. oCntErr pulses the next cycle if beats (including an ItemValid coincident with ItemEnd) != cnt.
    - iROB_ItemEnd in IDLE or ISSUE is ignored.
- oBusy = (state != IDLE). oPending is registered and updates the cycle after an allocate or free.
- Latency: IDLE selection to oROB_Rd is 1 cycle. ItemEnd to the next possible oROB_Rd is 2 cycles (IDLE, then ISSUE).
- Simultaneous free and miss-allocate in one cycle: the freed slot is not reusable until the next cycle; the miss sees the table as full if it was full.

Test Plan:
- Enqueue rows 0x10, 0x20, 0x10 with iDrainEn=0 -> oPending=2, cnt(0x10)=2. Then iDrainEn=1 with no open row -> oROB_Rd with oROB_Row=0x10 (largest cnt).
- Open row 0x20 valid, entries 0x10 (cnt 3) and 0x20 (cnt 1) -> drains 0x20 first. After ItemEnd with 1 beat -> oCntErr=0 and oPending=1.
- Hold iDrainEn=0 for 70 cycles with entry 0x30 aged, then enable with open row 0x40 also pending -> 0x30 drained first (age==63 beats open-row hit).
- Fill 4 distinct rows, enqueue a 5th row -> oEnqReady=0. Enqueue 8 items to one row -> 9th gets oEnqReady=0 and that row drains first.
- During WAIT_END for row 0x10, enqueue 0x10 -> oEnqReady=0. Deliver 2 beats against cnt=3 -> oCntErr pulses once, entry freed.
- Assert reset in WAIT_END -> all outputs 0 immediately, oPending=0; a subsequent enqueue allocates entry 0.
